// File: rtl/sigmon_pattern_multi.sv
// sigmon_pattern_multi: passive AXI4-Stream monitor that extracts a byte
// field from a chosen beat of each packet and raises match/sample events.
module sigmon_pattern_multi #(
  parameter  int DATA_BYTES = 32,
  parameter  int PAT_BYTES  = 6,
  parameter  int LINE_W     = 3,
  localparam int OFF_W      = $clog2(DATA_BYTES),
  localparam int DW         = DATA_BYTES * 8,
  localparam int PW         = PAT_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stream_vld,
  input  logic                 stream_rdy,
  input  logic                 stream_last,
  input  logic [DW-1:0]        stream_data,
  input  logic                 pattern_enable,
  input  logic                 pattern_disable,
  input  logic [1:0]           pattern_mode,
  input  logic [OFF_W-1:0]     pattern_offset,
  input  logic [LINE_W-1:0]    pattern_line,
  input  logic [PAT_BYTES-1:0] pattern_mask,
  input  logic [PW-1:0]        pattern_lo,
  input  logic [PW-1:0]        pattern_hi,
  input  logic [15:0]          threshold,
  input  logic                 clear_counters,
  output logic                 match_event_out,
  output logic                 sample_event_out,
  output logic [PW-1:0]        sample_data_out,
  output logic [31:0]          hit_count,
  output logic [31:0]          pkt_count,
  output logic                 active_out
);

  localparam logic [1:0] M_EQ  = 2'd0;
  localparam logic [1:0] M_SMP = 2'd1;
  localparam logic [1:0] M_RNG = 2'd2;
  localparam logic [LINE_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_IN_PKT} state_t;

  state_t state, state_nx;

  logic en_q, dis_q, en_rise, dis_rise;
  logic beat, sop, mon, pkt_end;
  logic [LINE_W-1:0] beat_cnt, cur_idx;

  assign en_rise  = pattern_enable & ~en_q;
  assign dis_rise = pattern_disable & ~dis_q;
  assign beat     = stream_vld & stream_rdy;
  assign cur_idx  = sop ? '0 : beat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q  <= 1'b0;
      dis_q <= 1'b0;
    end else begin
      en_q  <= pattern_enable;
      dis_q <= pattern_disable;
    end
  end

  // Packet boundaries are followed even while idle so arming
  // always lines up with a genuine start of packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop      <= 1'b1;
      beat_cnt <= '0;
    end else if (beat) begin
      sop <= stream_last;
      if (stream_last)
        beat_cnt <= '0;
      else if (cur_idx != IDX_MAX)
        beat_cnt <= cur_idx + 1'b1;
      else
        beat_cnt <= cur_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (dis_rise) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (en_rise) state_nx = S_ARMED;
        S_ARMED:
          if (beat && sop && !stream_last)
            state_nx = S_IN_PKT;
        S_IN_PKT:
          if (beat && stream_last)
            state_nx = S_ARMED;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    active_out = (state == S_ARMED) ||
                 (state == S_IN_PKT);
  end

  assign mon = beat & ~dis_rise &
               (((state == S_ARMED) & sop) |
                (state == S_IN_PKT));
  assign pkt_end = mon & stream_last;

  // fld_a: in-beat bytes, fld_b: bytes spilling into the next beat
  logic [PW-1:0] fld_a, fld_b, fld_a5;
  logic          spill;

  always_comb begin
    fld_a  = '0;
    fld_b  = '0;
    fld_a5 = '0;
    spill  = 1'b0;
    for (int k = 0; k < PAT_BYTES; k++) begin
      if (int'(pattern_offset) + k < DATA_BYTES) begin
        fld_a[PW-1-8*k -: 8] =
          stream_data[DW-1-8*(int'(pattern_offset)+k) -: 8];
        fld_a5[PW-1-8*k -: 8] = fld_a[PW-1-8*k -: 8];
      end else begin
        spill = 1'b1;
        fld_b[PW-1-8*k -: 8] = stream_data[
          DW-1-8*(int'(pattern_offset)+k-DATA_BYTES) -: 8];
        fld_a5[PW-1-8*k -: 8] = 8'hA5;
      end
    end
  end

  logic          tgt_done, pend, hit_q;
  logic [PW-1:0] part_q, fld_q;
  logic          is_tgt, is_fill, cmpl, cond;
  logic [PW-1:0] fld_now, keep, mf, ml, mh;

  assign is_tgt  = mon & ~tgt_done &
                   (cur_idx == pattern_line);
  assign is_fill = mon & pend;

  always_comb begin
    cmpl    = 1'b0;
    fld_now = fld_a;
    unique case (1'b1)
      is_fill: begin
        cmpl    = 1'b1;
        fld_now = part_q | fld_b;
      end
      is_tgt && !spill: begin
        cmpl    = 1'b1;
        fld_now = fld_a;
      end
      is_tgt && spill && stream_last: begin
        cmpl    = 1'b1;
        fld_now = fld_a5;
      end
      default: ;
    endcase
  end

  always_comb begin
    keep = '0;
    for (int k = 0; k < PAT_BYTES; k++)
      keep[PW-1-8*k -: 8] = {8{~pattern_mask[k]}};
  end

  assign mf = fld_now & keep;
  assign ml = pattern_lo & keep;
  assign mh = pattern_hi & keep;

  always_comb begin
    cond = 1'b0;
    unique case (pattern_mode)
      M_EQ:    cond = (mf == ml);
      M_SMP:   cond = 1'b1;
      M_RNG:   cond = (mf >= ml) && (mf <= mh);
      default: cond = (mf != ml);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_done <= 1'b0;
      pend     <= 1'b0;
      hit_q    <= 1'b0;
      part_q   <= '0;
      fld_q    <= '0;
    end else if (dis_rise || pkt_end) begin
      tgt_done <= 1'b0;
      pend     <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (is_tgt) begin
        tgt_done <= 1'b1;
        pend     <= spill;
        part_q   <= fld_a;
      end
      if (is_fill) pend <= 1'b0;
      if (cmpl) begin
        hit_q <= cond;
        fld_q <= fld_now;
      end
    end
  end

  logic          res_hit;
  logic [PW-1:0] res_fld;
  logic [15:0]   dec_cnt, thr_q, thr_eff;
  logic          is_smp;

  assign res_hit = hit_q | (cmpl & cond);
  assign res_fld = cmpl ? fld_now : fld_q;
  assign thr_eff = (threshold == 16'd0) ? 16'd1 : threshold;
  assign is_smp  = (pattern_mode == M_SMP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_event_out  <= 1'b0;
      sample_event_out <= 1'b0;
      sample_data_out  <= '0;
      dec_cnt          <= '0;
      thr_q            <= '0;
    end else begin
      match_event_out  <= 1'b0;
      sample_event_out <= 1'b0;
      thr_q            <= threshold;
      if (threshold != thr_q) begin
        dec_cnt <= '0;
      end else if (pkt_end && res_hit && !is_smp) begin
        if (dec_cnt + 16'd1 >= thr_eff) begin
          match_event_out <= 1'b1;
          dec_cnt         <= '0;
        end else begin
          dec_cnt <= dec_cnt + 16'd1;
        end
      end
      if (pkt_end && res_hit && is_smp) begin
        sample_event_out <= 1'b1;
        sample_data_out  <= res_fld;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
      pkt_count <= '0;
    end else if (clear_counters) begin
      hit_count <= '0;
      pkt_count <= '0;
    end else if (pkt_end) begin
      if (pkt_count != '1)
        pkt_count <= pkt_count + 32'd1;
      if (res_hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: doc/sigmon_pattern_multi.md
SIGMON_PATTERN_MULTI -- requirements
Module: sigmon_pattern_multi

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 32, meaning stream beat width in bytes (power of 2, 8..64).
REQ-002 SHALL have parameter PAT_BYTES, default 6, meaning field width in bytes (1..8, at most DATA_BYTES).
REQ-003 SHALL have parameter LINE_W, default 3, meaning line-counter width.
REQ-004 SHALL have clk  in  1  the single clock.
REQ-005 SHALL have reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have stream_vld, stream_rdy, stream_last  in  1 each  monitored AXI4-Stream handshake; passive, never driven.
REQ-007 SHALL have stream_data  in  DATA_BYTES*8  beat data; byte 0 is stream_data[top:top-7].
REQ-008 SHALL have pattern_enable, pattern_disable  in  1 each  level controls, acted on at rising edge only.
REQ-009 SHALL have pattern_mode  in  2  0=EQ, 1=SAMPLE, 2=RANGE, 3=NEQ.
REQ-010 SHALL have pattern_offset  in  clog2(DATA_BYTES)  byte offset of field byte 0 within the target line.
REQ-011 SHALL have pattern_line  in  LINE_W  target beat index within the packet, 0 = first beat.
REQ-012 SHALL have pattern_mask  in  PAT_BYTES  1 = field byte ignored.
REQ-013 SHALL have pattern_lo, pattern_hi  in  PAT_BYTES*8 each  EQ/NEQ use pattern_lo; RANGE uses both.
REQ-014 SHALL have threshold  in  16  hit decimation factor.
REQ-015 SHALL have clear_counters  in  1  synchronous pulse clearing the counters.
REQ-016 SHALL have match_event_out  out  1  one-cycle packet-level match event.
REQ-017 SHALL have sample_event_out  out  1  one-cycle packet-level sample event.
REQ-018 SHALL have sample_data_out  out  PAT_BYTES*8  last sampled field.
REQ-019 SHALL have hit_count, pkt_count  out  32 each  saturating statistics.
REQ-020 SHALL have active_out  out  1  high in ARMED or IN_PKT.

Function
REQ-021 SHALL define a beat as a cycle with stream_vld & stream_rdy; all other cycles are ignored (bubbles tolerated).
REQ-022 SHALL implement states IDLE, ARMED, IN_PKT: IDLE->ARMED on enable edge; ARMED->IN_PKT on a beat at packet start; IN_PKT->ARMED on the beat with stream_last; any state->IDLE on disable edge.
REQ-023 SHALL make a same-cycle enable and disable edge resolve to disable, and an enable mid-packet take effect only at the next packet start.
REQ-024 SHALL discard a packet in progress on disable: no events, no counter update.
REQ-025 SHALL track packet boundaries in all states, so that ARMED recognises the true next start of packet.
REQ-026 SHALL count beats per packet from 0, saturating at 2^LINE_W-1 (no wrap).
REQ-027 SHALL form the field from bytes pattern_offset..pattern_offset+PAT_BYTES-1 of the target beat, with byte 0 as the field MSB.
REQ-028 SHALL take overflow bytes (offset+k >= DATA_BYTES) from the beginning of the next beat of the same packet, holding the target beat across bubbles until that beat arrives.
REQ-029 SHALL fill overflow bytes with 0xA5 when the target beat is the last beat.
REQ-030 SHALL evaluate EQ as: all unmasked bytes equal pattern_lo; NEQ as: NOT EQ; RANGE as unsigned lo <= field <= hi, with masked bytes zeroed in field, lo and hi.
REQ-031 SHALL register a hit when the field is complete and the mode condition holds (SAMPLE: the field completes); no hit if the packet ends before the target beat.
REQ-032 SHALL register packet results at the clock edge accepting the last beat, with outputs high in the following cycle only (latency 1).
REQ-033 SHALL increment the hit counter for each match-mode packet with a hit, and assert match_event_out when the counter reaches max(threshold,1), then reset it to 0; a threshold change clears the counter.
REQ-034 SHALL, in SAMPLE mode, assert sample_event_out on every packet with a hit and update sample_data_out at the same edge; otherwise sample_data_out holds.
REQ-035 SHALL increment pkt_count per completed packet in IN_PKT, and hit_count per hit (both modes), each saturating at 0xFFFFFFFF.
REQ-036 SHALL clear both counters on clear_counters, with clear winning over a same-cycle increment.
REQ-037 SHALL treat a single-beat packet (start and last on the same beat) as a complete packet.

Reset
REQ-038 SHALL, on reset_n low, force immediately: state IDLE, all events 0, sample_data_out 0, counters 0, decimation counter 0, packet tracker expecting start of packet.
REQ-039 SHALL treat a packet in flight at reset release as unseen; monitoring resumes at the next start after an enable edge.

Verification
REQ-040 SHALL verify EQ spill: DATA_BYTES=32, offset 29, line 1, lo=0x0A0B0C0D0E0F, mask 0; 3-beat packet with beat 1 bytes 29-31 = 0A 0B 0C, beat 2 bytes 0-2 = 0D 0E 0F, 4 bubbles between beats -> one match_event_out one cycle after beat 2.
REQ-041 SHALL verify spill on the last beat: same setup, beat 1 is last -> field 0x0A0B0CA5A5A5, no event; NEQ mode -> event.
REQ-042 SHALL verify decimation: threshold 3, 7 matching packets -> events after packets 3 and 6 only; hit_count = 7, pkt_count = 7.
REQ-043 SHALL verify RANGE/SAMPLE: RANGE lo=0x10, hi=0x20 on value 0x20 -> event, 0x21 -> none; SAMPLE on a single-beat packet -> sample_event_out and sample_data_out = field.
REQ-044 SHALL verify mid-packet disable then enable: no event for that packet or the next partial one; first full packet after is monitored.
REQ-045 SHALL verify control collisions: reset_n asserted mid-packet -> outputs 0 immediately; clear_counters on the same cycle as a hit -> counters 0.
